alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  synchronous reset, active-low.
REQ-003 req_valid  in  1  operation request present.
REQ-004 req_ready  out  1  controller can accept a request.
REQ-005 req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV (passes b), 6 SLL, 7 SLR (rotate left), 8 SRL, 9 SRA, 10-15 illegal.
REQ-006 req_a, req_b  in  16 each  operands; shifts use a.
REQ-007 req_d  in  4  shift distance 0-15.
REQ-008 req_fwe  in  1  commit flags of this operation to flags_q.
REQ-009 res_valid  out  1  result held for consumer.
REQ-010 res_ready  in  1  consumer takes result.
REQ-011 res_data  out  16  result.
REQ-012 res_flags  out  4  {C,Z,V,S} of this operation.
REQ-013 res_err  out  1  operation was illegal.
REQ-014 flags_q  out  4  architectural flag register {C,Z,V,S}.
REQ-015 busy  out  1  state not IDLE.

Function
REQ-016 FSM SHALL have states IDLE, SHIFT, DONE; req_ready=1 only in IDLE; request accepted on req_valid&req_ready.
REQ-017 Non-shift op, shift with req_d=0, or illegal op SHALL go IDLE->DONE; res_valid asserted the cycle after acceptance (latency 1).
REQ-018 Shift with req_d!=0 and iterative mode SHALL go IDLE->SHIFT, shift one bit per cycle with a 4-bit down-counter loaded with req_d, enter DONE after the last bit; res_valid asserted req_d+1 cycles after acceptance.
REQ-019 DONE SHALL hold res_valid, res_data, res_flags, res_err stable until res_valid&res_ready, then go IDLE; no new request accepted in that handshake cycle.
REQ-020 ADD/SUB: 16-bit wrap result; C = carry-out (ADD) or borrow (SUB); V = two's-complement signed overflow.
REQ-021 AND/OR/XOR/MOV/SLR: C=0, V=0.
REQ-022 SLL/SRL/SRA: zero-fill (SRA sign-fill); C = last bit shifted out, 0 when d=0; V=0.
REQ-023 All ops: S=res_data[15], Z=(res_data==0).
REQ-024 Illegal op: res_data=0, res_flags=0, res_err=1, flags_q not updated regardless of req_fwe.
REQ-025 flags_q SHALL load res_flags on the same edge res_valid rises, only when captured req_fwe=1; otherwise unchanged.
REQ-026 Operands, op, d, fwe SHALL be captured at acceptance; later input changes have no effect.
REQ-027 res_data/res_flags/res_err SHALL be 0 while res_valid=0.

Reset
REQ-028 rst_n=0 at an edge SHALL force IDLE, counter 0, res_valid=0, res_data=0, res_flags=0, res_err=0, flags_q=0, busy=0, req_ready=1 after release.
REQ-029 Reset during SHIFT or DONE SHALL abort the operation; no result delivered, flags_q cleared.

Configuration
REQ-030 Macro ALU_ITER_SHIFT_EN defined: shifts iterative per REQ-018 (latency d+1).
REQ-031 Macro undefined: shifts via single-cycle barrel, SHIFT state unused, every op latency 1; results and flags identical in both builds.

Verification
REQ-032 ADD a=0x7FFF b=0x0001 fwe=1 -> res_data=0x8000, {C,Z,V,S}=0011, res_valid next cycle, flags_q=0011.
REQ-033 SUB a=0x0005 b=0x0005 fwe=0 -> res_data=0x0000, flags=0100, flags_q unchanged.
REQ-034 SRA a=0x8001 d=1 -> 0xC000, flags=1001; latency 2 with ALU_ITER_SHIFT_EN, 1 without; SLL a=0x8001 d=4 -> 0x0010, C=0.
REQ-035 res_ready low 3 cycles after result -> outputs stable, req_ready=0, busy=1; release -> IDLE next cycle.
REQ-036 op=12 fwe=1 -> res_err=1, res_data=0, flags_q unchanged.
REQ-037 ALU_ITER_SHIFT_EN, SLL d=15, rst_n low 5 cycles after accept -> IDLE, res_valid never asserted, flags_q=0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl -- sequencing controller around a 16-bit ALU.
//
// Accepts one operation at a time over a valid/ready request channel, computes
// the result, holds it on a valid/ready result channel, and optionally commits
// the {C,Z,V,S} flags of the operation into an architectural flag register.
//
// Build option:
//   ALU_ITER_SHIFT_EN defined   -> shifts with a non-zero distance step one bit
//                                  per cycle in SHIFT (latency d+1).
//   ALU_ITER_SHIFT_EN undefined -> shifts use a single-cycle barrel shifter,
//                                  SHIFT is never entered, every op has latency 1.
// Results and flags are identical in both builds.
//
// State table:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a request (req_ready=1)
//   ST_SHIFT | iterative shift in progress, cnt_q bits still to shift
//   ST_DONE  | result held on res_* until the consumer takes it

module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_d,
    input  logic        req_fwe,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [3:0]  res_flags,
    output logic        res_err,
    output logic [3:0]  flags_q,
    output logic        busy
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SLR = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [15:0] res_data_q, res_data_d;
    logic [3:0]  res_flags_q, res_flags_d;
    logic        res_err_q, res_err_d;
    logic [3:0]  flags_d;

    // Flag layout is {C,Z,V,S}; Z and S always follow the result value.
    function automatic logic [3:0] pack_flags(input logic [15:0] r,
                                              input logic        c,
                                              input logic        v);
        return {c, (r == 16'h0000), v, r[15]};
    endfunction

    logic [16:0] sum17;
    logic [16:0] diff17;
    logic [15:0] alu_res;
    logic        alu_c;
    logic        alu_v;
    logic        alu_ill;
    logic [3:0]  alu_flags;
    logic        take_iter;

    // Bit 16 of the difference is the borrow out of the subtraction.
    assign sum17  = {1'b0, req_a} + {1'b0, req_b};
    assign diff17 = {1'b0, req_a} - {1'b0, req_b};

`ifdef ALU_ITER_SHIFT_EN
    logic        is_shift;
    logic [15:0] work_q, work_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic        fwe_q, fwe_d;
    logic [15:0] step_w;
    logic        step_c;
    logic [3:0]  step_flags;

    assign is_shift  = (req_op == OP_SLL) || (req_op == OP_SLR) ||
                       (req_op == OP_SRL) || (req_op == OP_SRA);
    // A zero-distance shift is an identity with C=0, so it takes the 1-cycle path.
    assign take_iter = is_shift && (req_d != 4'd0);
`else
    logic [16:0]        sll17;
    logic [16:0]        srl17;
    logic signed [16:0] sra17;
    logic [15:0]        rot16;

    // One guard bit beside the operand catches the last bit shifted out;
    // it stays 0 when the distance is 0.
    assign sll17 = {1'b0, req_a} << req_d;
    assign srl17 = {req_a, 1'b0} >> req_d;
    assign sra17 = $signed({req_a, 1'b0}) >>> req_d;
    // a >> (16-d) written as (a >> (15-d)) >> 1 keeps d=0 well defined.
    assign rot16 = (req_a << req_d) | ((req_a >> (~req_d)) >> 1);

    assign take_iter = 1'b0;
`endif

    // Single-cycle ALU evaluated on the live request inputs.
    always_comb begin
        alu_res = 16'h0000;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (req_op)
            OP_ADD: begin
                alu_res = sum17[15:0];
                alu_c   = sum17[16];
                alu_v   = (req_a[15] == req_b[15]) && (sum17[15] != req_a[15]);
            end
            OP_SUB: begin
                alu_res = diff17[15:0];
                alu_c   = diff17[16];
                alu_v   = (req_a[15] != req_b[15]) && (diff17[15] != req_a[15]);
            end
            OP_AND: alu_res = req_a & req_b;
            OP_OR:  alu_res = req_a | req_b;
            OP_XOR: alu_res = req_a ^ req_b;
            OP_MOV: alu_res = req_b;
`ifdef ALU_ITER_SHIFT_EN
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: alu_res = req_a;
`else
            OP_SLL: begin
                alu_res = sll17[15:0];
                alu_c   = sll17[16];
            end
            OP_SLR: alu_res = rot16;
            OP_SRL: begin
                alu_res = srl17[16:1];
                alu_c   = srl17[0];
            end
            OP_SRA: begin
                alu_res = sra17[16:1];
                alu_c   = sra17[0];
            end
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    assign alu_flags = alu_ill ? 4'b0000 : pack_flags(alu_res, alu_c, alu_v);

`ifdef ALU_ITER_SHIFT_EN
    // One-bit shift step applied to the working register while in SHIFT.
    always_comb begin
        step_w = work_q;
        step_c = 1'b0;
        case (op_q)
            OP_SLL: begin
                step_c = work_q[15];
                step_w = {work_q[14:0], 1'b0};
            end
            OP_SRL: begin
                step_c = work_q[0];
                step_w = {1'b0, work_q[15:1]};
            end
            OP_SRA: begin
                step_c = work_q[0];
                step_w = {work_q[15], work_q[15:1]};
            end
            OP_SLR: step_w = {work_q[14:0], work_q[15]};
            default: ;
        endcase
    end

    assign step_flags = pack_flags(step_w, step_c, 1'b0);

    // Capture the shift operation at acceptance, then step the down-counter.
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        fwe_d  = fwe_q;
        if ((state_q == ST_IDLE) && req_valid && take_iter) begin
            work_d = req_a;
            cnt_d  = req_d;
            op_d   = req_op;
            fwe_d  = req_fwe;
        end else if (state_q == ST_SHIFT) begin
            work_d = step_w;
            cnt_d  = cnt_q - 4'd1;
        end
    end

    // Iterative shifter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_q <= 16'h0000;
            cnt_q  <= 4'd0;
            op_q   <= 4'd0;
            fwe_q  <= 1'b0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            fwe_q  <= fwe_d;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = take_iter ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
`ifdef ALU_ITER_SHIFT_EN
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        res_valid = (state_q == ST_DONE);
    end

    // Result and flag-register next values; results load on the edge that
    // enters DONE and are cleared on the handshake so they read 0 when invalid.
    always_comb begin
        res_data_d  = res_data_q;
        res_flags_d = res_flags_q;
        res_err_d   = res_err_q;
        flags_d     = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !take_iter) begin
                    res_data_d  = alu_res;
                    res_flags_d = alu_flags;
                    res_err_d   = alu_ill;
                    if (req_fwe && !alu_ill) begin
                        flags_d = alu_flags;
                    end
                end
            end
            ST_SHIFT: begin
`ifdef ALU_ITER_SHIFT_EN
                if (cnt_q == 4'd1) begin
                    res_data_d  = step_w;
                    res_flags_d = step_flags;
                    res_err_d   = 1'b0;
                    if (fwe_q) begin
                        flags_d = step_flags;
                    end
                end
`endif
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_data_d  = 16'h0000;
                    res_flags_d = 4'b0000;
                    res_err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Result and architectural flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_data_q  <= 16'h0000;
            res_flags_q <= 4'b0000;
            res_err_q   <= 1'b0;
            flags_q     <= 4'b0000;
        end else begin
            res_data_q  <= res_data_d;
            res_flags_q <= res_flags_d;
            res_err_q   <= res_err_d;
            flags_q     <= flags_d;
        end
    end

    assign res_data  = res_data_q;
    assign res_flags = res_flags_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: a table of operations with hand-derived
// results, a scoreboard queue of expected results, and a few hand sequences
// for back-pressure and reset-abort. Adapts expected latency to the
// ALU_ITER_SHIFT_EN build option.

module tb_alu_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_d;
    logic        req_fwe;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [3:0]  res_flags;
    logic        res_err;
    logic [3:0]  flags_q;
    logic        busy;

    alu_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_d     (req_d),
        .req_fwe   (req_fwe),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flags (res_flags),
        .res_err   (res_err),
        .flags_q   (flags_q),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  d;
        logic        fwe;
        logic [15:0] data;
        logic [3:0]  flags;
        logic        err;
    } vec_t;

    vec_t       vecs [18];
    vec_t       sb [$];
    int         n_cmp;
    int         n_bad;
    logic [3:0] exp_fq;

    function automatic vec_t mk(input logic [3:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic [3:0] d,
                                input logic fwe, input logic [15:0] data,
                                input logic [3:0] flags, input logic err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.d = d; v.fwe = fwe;
        v.data = data; v.flags = flags; v.err = err;
        return v;
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [3:0] d);
`ifdef ALU_ITER_SHIFT_EN
        if (op >= 4'd6 && op <= 4'd9 && d != 4'd0) return int'(d) + 1;
`endif
        return 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        req_d     = v.d;
        req_fwe   = v.fwe;
    endtask

    task automatic scramble();
        req_op  = 4'($urandom);
        req_a   = 16'($urandom);
        req_b   = 16'($urandom);
        req_d   = 4'($urandom);
        req_fwe = 1'($urandom);
    endtask

    task automatic check_result(input int lat);
        vec_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("res_data",  32'(res_data),  32'(e.data));
        chk("res_flags", 32'(res_flags), 32'(e.flags));
        chk("res_err",   32'(res_err),   32'(e.err));
        chk("latency",   32'(lat),       32'(exp_lat(e.op, e.d)));
        if (e.fwe && !e.err) exp_fq = e.flags;
        chk("flags_q",   32'(flags_q),   32'(exp_fq));
    endtask

    // One full transaction: drive, change inputs after acceptance, wait for
    // the result, compare against the scoreboard, then take it.
    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        req_valid = 1'b0;
        scramble();
        lat = 1;
        while (!res_valid && lat < 40) begin
            chk("res_data_zero_pending", 32'(res_data), 32'd0);
            chk("busy_pending", 32'(busy), 32'd1);
            @(negedge clk);
            lat++;
        end
        chk("res_valid_seen", 32'(res_valid), 32'd1);
        if (res_valid) check_result(lat);
        else if (sb.size() != 0) void'(sb.pop_front());
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_after_take", 32'(res_valid), 32'd0);
        chk("res_data_after_take",  32'(res_data),  32'd0);
        chk("res_flags_after_take", 32'(res_flags), 32'd0);
        chk("busy_after_take",      32'(busy),      32'd0);
        chk("flags_q_after_take",   32'(flags_q),   32'(exp_fq));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        n_cmp  = 0;
        n_bad  = 0;
        exp_fq = 4'b0000;

        //          op     a         b         d     fwe   data      CZVS     err
        vecs[0]  = mk(4'd0,  16'h7FFF, 16'h0001, 4'd0,  1'b1, 16'h8000, 4'b0011, 1'b0);
        vecs[1]  = mk(4'd1,  16'h0005, 16'h0005, 4'd0,  1'b0, 16'h0000, 4'b0100, 1'b0);
        vecs[2]  = mk(4'd9,  16'h8001, 16'h0000, 4'd1,  1'b0, 16'hC000, 4'b1001, 1'b0);
        vecs[3]  = mk(4'd6,  16'h8001, 16'h0000, 4'd4,  1'b0, 16'h0010, 4'b0000, 1'b0);
        vecs[4]  = mk(4'd0,  16'hFFFF, 16'h0001, 4'd0,  1'b1, 16'h0000, 4'b1100, 1'b0);
        vecs[5]  = mk(4'd1,  16'h0000, 16'h0001, 4'd0,  1'b1, 16'hFFFF, 4'b1001, 1'b0);
        vecs[6]  = mk(4'd1,  16'h8000, 16'h0001, 4'd0,  1'b1, 16'h7FFF, 4'b0010, 1'b0);
        vecs[7]  = mk(4'd2,  16'hF0F0, 16'h0FF0, 4'd0,  1'b0, 16'h00F0, 4'b0000, 1'b0);
        vecs[8]  = mk(4'd3,  16'h0000, 16'h0000, 4'd0,  1'b0, 16'h0000, 4'b0100, 1'b0);
        vecs[9]  = mk(4'd4,  16'hAAAA, 16'h5555, 4'd0,  1'b1, 16'hFFFF, 4'b0001, 1'b0);
        vecs[10] = mk(4'd5,  16'hFFFF, 16'h1234, 4'd0,  1'b0, 16'h1234, 4'b0000, 1'b0);
        vecs[11] = mk(4'd7,  16'h8001, 16'h0000, 4'd4,  1'b0, 16'h0018, 4'b0000, 1'b0);
        vecs[12] = mk(4'd8,  16'hC001, 16'h0000, 4'd15, 1'b0, 16'h0001, 4'b1000, 1'b0);
        vecs[13] = mk(4'd6,  16'h8001, 16'h0000, 4'd0,  1'b1, 16'h8001, 4'b0001, 1'b0);
        vecs[14] = mk(4'd12, 16'h0001, 16'h0001, 4'd3,  1'b1, 16'h0000, 4'b0000, 1'b1);
        vecs[15] = mk(4'd9,  16'h4000, 16'h0000, 4'd15, 1'b1, 16'h0000, 4'b1100, 1'b0);
        vecs[16] = mk(4'd15, 16'hFFFF, 16'hFFFF, 4'd0,  1'b1, 16'h0000, 4'b0000, 1'b1);
        vecs[17] = mk(4'd1,  16'h0001, 16'h0002, 4'd0,  1'b1, 16'hFFFF, 4'b1001, 1'b0);

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = 16'h0000;
        req_b     = 16'h0000;
        req_d     = 4'd0;
        req_fwe   = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_res_flags", 32'(res_flags), 32'd0);
        chk("rst_res_err",   32'(res_err),   32'd0);
        chk("rst_flags_q",   32'(flags_q),   32'd0);

        for (int i = 0; i < 18; i++) run_vec(vecs[i]);

        // Back-pressure: result held while res_ready is low, no acceptance
        // while DONE nor in the handshake cycle.
        @(negedge clk);
        drive(mk(4'd0, 16'h8000, 16'h8001, 4'd0, 1'b1, 16'h0001, 4'b1010, 1'b0));
        sb.push_back(mk(4'd0, 16'h8000, 16'h8001, 4'd0, 1'b1, 16'h0001, 4'b1010, 1'b0));
        @(negedge clk);
        req_op = 4'd4; req_a = 16'h1111; req_b = 16'h2222;
        chk("stall_valid", 32'(res_valid), 32'd1);
        if (res_valid) check_result(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_res_valid", 32'(res_valid), 32'd1);
            chk("stall_res_data",  32'(res_data),  32'h0001);
            chk("stall_res_flags", 32'(res_flags), 32'b1010);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_busy",      32'(busy),      32'd1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        res_ready = 1'b0;
        chk("release_busy",      32'(busy),      32'd0);
        chk("release_res_valid", 32'(res_valid), 32'd0);
        chk("release_req_ready", 32'(req_ready), 32'd1);
        chk("release_flags_q",   32'(flags_q),   32'b1010);

        // Reset while a result is held in DONE.
        @(negedge clk);
        drive(mk(4'd4, 16'h00FF, 16'h0F0F, 4'd0, 1'b0, 16'h0FF0, 4'b0000, 1'b0));
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstdone_valid", 32'(res_valid), 32'd1);
        chk("rstdone_data",  32'(res_data),  32'h0FF0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        exp_fq = 4'b0000;
        chk("rstdone_busy",      32'(busy),      32'd0);
        chk("rstdone_res_valid", 32'(res_valid), 32'd0);
        chk("rstdone_res_data",  32'(res_data),  32'd0);
        chk("rstdone_flags_q",   32'(flags_q),   32'd0);
        chk("rstdone_req_ready", 32'(req_ready), 32'd1);

`ifdef ALU_ITER_SHIFT_EN
        // Reset in the middle of a long iterative shift aborts it.
        run_vec(vecs[0]);
        @(negedge clk);
        drive(mk(4'd6, 16'hFFFF, 16'h0000, 4'd15, 1'b1, 16'h8000, 4'b1001, 1'b0));
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_pre",  32'(busy),      32'd1);
        chk("abort_valid_pre", 32'(res_valid), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        exp_fq = 4'b0000;
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_flags_q",   32'(flags_q),   32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen),    32'd0);
        chk("abort_flags_q_2", 32'(flags_q), 32'd0);
`endif

        // Recovery after reset.
        run_vec(vecs[2]);
        run_vec(vecs[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
